cgra0_run_ctrl: RTL and testbench
=================================

# cgra0_run_ctrl

Run controller for the cgra0 array. It streams configuration words from the host onto the 64-bit configuration chain that feeds every PE's configuration reader, then waits for the chain to settle. It then drives the global PE enable `en`, stalling the whole array whenever an input stream runs low or an output buffer nears full, and finishes the run when every output stream reports completion.

## Interface
Parameters:
- CONF_WIDTH, 64, width of host configuration words and of `conf_bus_out`.
- NUM_IN, 4, number of input streams (PE input FIFOs).
- NUM_OUT, 4, number of output streams.
- CONF_DRAIN, 8, idle cycles after the last configuration word before the run starts; covers configuration-chain depth.

Ports:
- clk  in  1  clock; the block has one clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse; begins a configure-and-run sequence; ignored unless idle.
- abort  in  1  forces return to IDLE.
- conf_cnt  in  16  number of configuration words for this run; sampled on an accepted `start`.
- conf_data  in  CONF_WIDTH  host configuration word.
- conf_valid  in  1  `conf_data` is valid.
- conf_ready  out  1  the controller accepts a configuration word this cycle.
- conf_bus_out  out  CONF_WIDTH  registered word driven onto the PE configuration chain.
- in_low  in  NUM_IN  the input FIFO holds fewer than 2 words.
- in_done  in  NUM_IN  the input stream has delivered all of its data.
- out_afull  in  NUM_OUT  the output FIFO has 2 or fewer free slots.
- out_done  in  NUM_OUT  the output stream has received its full quantity.
- en  out  1  registered global PE enable.
- busy  out  1  the state is not IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- run_cycles  out  32  number of cycles with `en`=1 in the current or last run.

## Operation
- States: IDLE, CONF, DRAIN, RUN, DONE. The state is held in a register.
- IDLE:
  - `en`=0, `conf_ready`=0, `conf_bus_out`=0.
  - On `start`, the controller clears `run_cycles`, loads `conf_cnt` into the word counter, and moves to CONF if `conf_cnt`≠0.
  - On `start` with `conf_cnt`=0, it moves straight to RUN and keeps the configuration already loaded.
- CONF:
  - `conf_ready`=1.
  - On each handshake (`conf_valid & conf_ready`), `conf_bus_out` <= `conf_data` and the word counter decrements.
  - Any cycle without a handshake drives `conf_bus_out` <= 0. The all-zero word is the chain idle word.
  - The handshake that brings the counter to 0 moves the state to DRAIN.
- DRAIN: `conf_bus_out`=0 and `conf_ready`=0. After exactly CONF_DRAIN cycles the state moves to RUN.
- RUN:
  - stall = |(`in_low` & ~`in_done`) | |`out_afull`.
  - Each cycle, `en` <= ~stall while the next state is RUN; otherwise `en` <= 0.
  - `run_cycles` increments on every cycle where `en`=1 and saturates at 2^32-1.
  - When &`out_done` is high, the next state is DONE. Completion takes precedence over stall.
- DONE: `en`=0 and `done`=1 for this single cycle, then the state returns to IDLE. `run_cycles` holds its value until the next accepted `start`.
- `abort`:
  - In any state, the next state is IDLE.
  - `en`, `conf_ready` and `conf_bus_out` are 0 from the next cycle.
  - `done` is not pulsed. `abort` takes precedence over `start` and over completion.
- `start` while `busy`=1 is ignored.

## Timing
- Reset values: state=IDLE; `en`, `conf_ready`, `done`, `busy`=0; `conf_bus_out`=0; `run_cycles`=0; word and drain counters=0.
- `start` sampled at cycle t: `busy`=1 and `conf_ready`=1 at t+1.
- A word accepted at cycle c appears on `conf_bus_out` at c+1.
- Last word accepted at cycle c:
  - DRAIN occupies c+1 .. c+CONF_DRAIN.
  - RUN begins at c+CONF_DRAIN+1.
  - `en` is first high at c+CONF_DRAIN+2 if there is no stall.
- The `en` response to stall is one cycle late. For this reason `in_low` and `out_afull` carry one word of margin.
- `out_done` all high sampled at cycle d: DONE at d+1 with `en`=0 and `done`=1; IDLE at d+2.
- `conf_cnt`=0 path: `start` at t gives RUN at t+1 and the first possible `en` at t+2.

## Test plan
- Reset, then idle for 10 cycles: all outputs 0, `busy`=0.
- `conf_cnt`=3 with words 0x11, 0x22, 0x33 sent with a 2-cycle gap before 0x33 and CONF_DRAIN=8:
  - `conf_bus_out` shows 0x11, 0x22, 0, 0, 0x33 with one-cycle latency.
  - `en` rises exactly 10 cycles after 0x33 is accepted.
- In RUN, `in_low[1]`=1 for 5 cycles: `en` is low for 5 cycles, shifted by one. Repeat with `in_done[1]`=1: no stall.
- `out_afull[0]` and &`out_done` asserted in the same cycle: DONE next cycle, a single `done` pulse, and `run_cycles` equals the number of `en`-high cycles.
- `abort` mid-CONF after 1 of 4 words: IDLE next cycle, `conf_ready`=0, no `done`. A new `start` then accepts 4 fresh words.
- `start` pulsed during RUN is ignored; `start` with `conf_cnt`=0 gives `en` high 2 cycles after `start`.

Source files
------------

// File: rtl/cgra0_run_ctrl.sv
// cgra0_run_ctrl: run controller for the cgra0 array.
// Streams host configuration words onto the PE configuration chain, lets the
// chain settle, then drives the global PE enable until every output stream
// reports completion. The array is stalled whenever an input stream runs low
// or an output buffer nears full.
module cgra0_run_ctrl #(
  parameter int CONF_WIDTH = 64,
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 4,
  parameter int CONF_DRAIN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           conf_cnt,
  input  logic [CONF_WIDTH-1:0] conf_data,
  input  logic                  conf_valid,
  output logic                  conf_ready,
  output logic [CONF_WIDTH-1:0] conf_bus_out,
  input  logic [NUM_IN-1:0]     in_low,
  input  logic [NUM_IN-1:0]     in_done,
  input  logic [NUM_OUT-1:0]    out_afull,
  input  logic [NUM_OUT-1:0]    out_done,
  output logic                  en,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           run_cycles
);

  // The drain counter only has to hold CONF_DRAIN-1; it counts down to zero.
  localparam int DW = (CONF_DRAIN < 2) ? 1 : $clog2(CONF_DRAIN);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(CONF_DRAIN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONF,
    S_DRAIN,
    S_RUN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [15:0]           r_wordCnt;
  logic [DW-1:0]         r_drainCnt;
  logic [CONF_WIDTH-1:0] r_confBus;
  logic                  r_en;
  logic [31:0]           r_runCycles;

  logic w_stall;
  logic w_allDone;
  logic w_startOk;

  // An input stream that has delivered everything may sit low without stalling.
  assign w_stall   = (|(in_low & ~in_done)) | (|out_afull);
  assign w_allDone = &out_done;
  assign w_startOk = start & (r_state == S_IDLE) & ~abort;

  assign conf_ready   = (r_state == S_CONF);
  assign conf_bus_out = r_confBus;
  assign en           = r_en;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign run_cycles   = r_runCycles;

  // Sequencer: state, word/drain counters, chain word and PE enable; the chain idles at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wordCnt  <= '0;
      r_drainCnt <= '0;
      r_confBus  <= '0;
      r_en       <= 1'b0;
    end else if (abort) begin
      r_state    <= S_IDLE;
      r_wordCnt  <= '0;
      r_drainCnt <= '0;
      r_confBus  <= '0;
      r_en       <= 1'b0;
    end else begin
      r_confBus <= '0;
      r_en      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wordCnt <= conf_cnt;
            r_state   <= (conf_cnt != 16'd0) ? S_CONF : S_RUN;
          end
        end
        S_CONF: begin
          if (conf_valid) begin
            r_confBus <= conf_data;
            r_wordCnt <= r_wordCnt - 16'd1;
            if (r_wordCnt == 16'd1) begin
              r_state    <= S_DRAIN;
              r_drainCnt <= DRAIN_LOAD;
            end
          end
        end
        S_DRAIN: begin
          if (r_drainCnt == '0) begin
            r_state <= S_RUN;
          end else begin
            r_drainCnt <= r_drainCnt - DW'(1);
          end
        end
        S_RUN: begin
          if (w_allDone) begin
            r_state <= S_DONE;
          end else begin
            r_en <= ~w_stall;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Enabled-cycle counter: cleared by an accepted start, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_runCycles <= '0;
    end else if (w_startOk) begin
      r_runCycles <= '0;
    end else if (r_en && (r_runCycles != 32'hFFFF_FFFF)) begin
      r_runCycles <= r_runCycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_cgra0_run_ctrl.sv
// tb_cgra0_run_ctrl: directed bench for cgra0_run_ctrl with a timestamp-based
// reference model and literal expectations for the key timing points.
module tb_cgra0_run_ctrl;

  localparam int CW = 64;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int CD = 8;

  localparam int M_IDLE  = 0;
  localparam int M_CONF  = 1;
  localparam int M_DRAIN = 2;
  localparam int M_RUN   = 3;
  localparam int M_DONE  = 4;

  // Run-phase vectors: inputs applied in each row and the en expected during that row.
  localparam logic [3:0] T_LOW   [0:14] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0,
                                            4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
  localparam logic [3:0] T_INDN  [0:14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                            4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
  localparam logic [3:0] T_AFULL [0:14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                            4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
  localparam logic [3:0] T_ODONE [0:14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                            4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
  localparam logic       T_EN    [0:14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [15:0]   conf_cnt;
  logic [CW-1:0] conf_data;
  logic          conf_valid;
  logic          conf_ready;
  logic [CW-1:0] conf_bus_out;
  logic [NI-1:0] in_low;
  logic [NI-1:0] in_done;
  logic [NO-1:0] out_afull;
  logic [NO-1:0] out_done;
  logic          en;
  logic          busy;
  logic          done;
  logic [31:0]   run_cycles;

  int checks   = 0;
  int failures = 0;
  bit cmpOn    = 1'b0;

  always #5 clk = ~clk;

  cgra0_run_ctrl #(
    .CONF_WIDTH(CW),
    .NUM_IN    (NI),
    .NUM_OUT   (NO),
    .CONF_DRAIN(CD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .conf_cnt    (conf_cnt),
    .conf_data   (conf_data),
    .conf_valid  (conf_valid),
    .conf_ready  (conf_ready),
    .conf_bus_out(conf_bus_out),
    .in_low      (in_low),
    .in_done     (in_done),
    .out_afull   (out_afull),
    .out_done    (out_done),
    .en          (en),
    .busy        (busy),
    .done        (done),
    .run_cycles  (run_cycles)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: phase plus timestamps; RUN begins CD edges after the last word's edge.
  int          edgeNo = 0;
  int          mMode;
  int          mWordsLeft;
  int          mRunEdge;
  logic [CW-1:0] mBus;
  logic        mEn;
  logic [31:0] mRun;

  always @(posedge clk) begin
    edgeNo <= edgeNo + 1;
    if (rst) begin
      mMode      <= M_IDLE;
      mWordsLeft <= 0;
      mRunEdge   <= 0;
      mBus       <= '0;
      mEn        <= 1'b0;
      mRun       <= '0;
    end else begin
      if (mMode == M_IDLE && start && !abort) mRun <= '0;
      else if (mEn && mRun != 32'hFFFF_FFFF) mRun <= mRun + 32'd1;
      mBus <= '0;
      mEn  <= 1'b0;
      if (abort) begin
        mMode <= M_IDLE;
      end else if (mMode == M_IDLE) begin
        if (start) begin
          mWordsLeft <= int'(conf_cnt);
          mMode      <= (conf_cnt == 16'd0) ? M_RUN : M_CONF;
        end
      end else if (mMode == M_CONF) begin
        if (conf_valid) begin
          mBus       <= conf_data;
          mWordsLeft <= mWordsLeft - 1;
          if (mWordsLeft == 1) begin
            mMode    <= M_DRAIN;
            mRunEdge <= edgeNo + CD;
          end
        end
      end else if (mMode == M_DRAIN) begin
        if (edgeNo == mRunEdge) mMode <= M_RUN;
      end else if (mMode == M_RUN) begin
        if (out_done == '1) mMode <= M_DONE;
        else mEn <= !(((in_low & ~in_done) != '0) || (out_afull != '0));
      end else begin
        mMode <= M_IDLE;
      end
    end
  end

  // Compare every output against the model on each falling edge once reset is done.
  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("cmp_en", {63'd0, en}, {63'd0, mEn});
      checkOutput("cmp_busy", {63'd0, busy}, {63'd0, (mMode != M_IDLE)});
      checkOutput("cmp_done", {63'd0, done}, {63'd0, (mMode == M_DONE)});
      checkOutput("cmp_conf_ready", {63'd0, conf_ready}, {63'd0, (mMode == M_CONF)});
      checkOutput("cmp_conf_bus", conf_bus_out, mBus);
      checkOutput("cmp_run_cycles", {32'd0, run_cycles}, {32'd0, mRun});
    end
  end

  // Directed stimulus with literal expectations at the key timing points.
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    conf_cnt   = 16'd0;
    conf_data  = '0;
    conf_valid = 1'b0;
    in_low     = '0;
    in_done    = '0;
    out_afull  = '0;
    out_done   = '0;
    applyStimulus(3);
    rst   = 1'b0;
    cmpOn = 1'b1;

    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_en", {63'd0, en}, 64'd0);
    checkOutput("rst_run_cycles", {32'd0, run_cycles}, 64'd0);
    checkOutput("rst_conf_bus", conf_bus_out, 64'd0);
    applyStimulus(10);

    // Three words, two idle cycles before the last.
    start    = 1'b1;
    conf_cnt = 16'd3;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("conf_busy", {63'd0, busy}, 64'd1);
    checkOutput("conf_ready_up", {63'd0, conf_ready}, 64'd1);
    conf_valid = 1'b1;
    conf_data  = 64'h11;
    applyStimulus(1);
    checkOutput("bus_w0", conf_bus_out, 64'h11);
    conf_data = 64'h22;
    applyStimulus(1);
    checkOutput("bus_w1", conf_bus_out, 64'h22);
    conf_valid = 1'b0;
    conf_data  = 64'hDEAD;
    applyStimulus(1);
    checkOutput("bus_gap0", conf_bus_out, 64'h0);
    applyStimulus(1);
    checkOutput("bus_gap1", conf_bus_out, 64'h0);
    conf_valid = 1'b1;
    conf_data  = 64'h33;
    applyStimulus(1);
    checkOutput("bus_w2", conf_bus_out, 64'h33);
    conf_data = 64'hBAD;
    for (int k = 1; k <= 10; k++) begin
      checkOutput($sformatf("drain_en_k%0d", k), {63'd0, en}, {63'd0, (k == 10)});
      if (k < 10) applyStimulus(1);
    end
    conf_valid = 1'b0;
    conf_data  = '0;

    // Run-phase table: stall, stall masked by in_done, then completion with afull.
    for (int r = 0; r < 15; r++) begin
      in_low    = T_LOW[r];
      in_done   = T_INDN[r];
      out_afull = T_AFULL[r];
      out_done  = T_ODONE[r];
      checkOutput($sformatf("tbl_en_r%0d", r), {63'd0, en}, {63'd0, T_EN[r]});
      applyStimulus(1);
    end
    in_low    = '0;
    in_done   = '0;
    out_afull = '0;
    out_done  = '0;
    checkOutput("fin_done", {63'd0, done}, 64'd1);
    checkOutput("fin_en", {63'd0, en}, 64'd0);
    checkOutput("fin_run_cycles", {32'd0, run_cycles}, 64'd10);
    applyStimulus(1);
    checkOutput("post_busy", {63'd0, busy}, 64'd0);
    checkOutput("post_done", {63'd0, done}, 64'd0);
    checkOutput("post_run_cycles", {32'd0, run_cycles}, 64'd10);
    applyStimulus(2);

    // Abort after one of four words, with a competing handshake in the abort cycle.
    start    = 1'b1;
    conf_cnt = 16'd4;
    applyStimulus(1);
    start      = 1'b0;
    conf_valid = 1'b1;
    conf_data  = 64'hA1;
    applyStimulus(1);
    checkOutput("ab_bus_w0", conf_bus_out, 64'hA1);
    abort     = 1'b1;
    conf_data = 64'hA2;
    applyStimulus(1);
    abort      = 1'b0;
    conf_valid = 1'b0;
    checkOutput("ab_busy", {63'd0, busy}, 64'd0);
    checkOutput("ab_conf_ready", {63'd0, conf_ready}, 64'd0);
    checkOutput("ab_bus", conf_bus_out, 64'h0);
    checkOutput("ab_done", {63'd0, done}, 64'd0);
    applyStimulus(2);

    // Fresh start after abort takes four new words.
    start    = 1'b1;
    conf_cnt = 16'd4;
    applyStimulus(1);
    start      = 1'b0;
    conf_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      conf_data = 64'hB1 + 64'(i);
      applyStimulus(1);
      checkOutput($sformatf("re_bus_w%0d", i), conf_bus_out, 64'hB1 + 64'(i));
    end
    conf_valid = 1'b0;
    conf_data  = '0;
    checkOutput("re_drain_ready", {63'd0, conf_ready}, 64'd0);
    applyStimulus(9);
    checkOutput("re_en_up", {63'd0, en}, 64'd1);

    // Start during RUN is ignored.
    start    = 1'b1;
    conf_cnt = 16'd0;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(1);
    checkOutput("ign_busy", {63'd0, busy}, 64'd1);
    checkOutput("ign_en", {63'd0, en}, 64'd1);
    out_done = '1;
    applyStimulus(1);
    out_done = '0;
    checkOutput("re_done", {63'd0, done}, 64'd1);
    applyStimulus(1);
    checkOutput("re_idle", {63'd0, busy}, 64'd0);

    // Zero-word start goes straight to RUN; en two cycles after start.
    start    = 1'b1;
    conf_cnt = 16'd0;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("z_busy", {63'd0, busy}, 64'd1);
    checkOutput("z_en_t1", {63'd0, en}, 64'd0);
    checkOutput("z_conf_ready", {63'd0, conf_ready}, 64'd0);
    checkOutput("z_run_clear", {32'd0, run_cycles}, 64'd0);
    applyStimulus(1);
    checkOutput("z_en_t2", {63'd0, en}, 64'd1);
    out_done = '1;
    applyStimulus(1);
    out_done = '0;
    checkOutput("z_done", {63'd0, done}, 64'd1);
    checkOutput("z_run_cycles", {32'd0, run_cycles}, 64'd1);
    applyStimulus(3);

    cmpOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
